// File: rtl/instr_buffer_pkg.sv
// instr_buffer_pkg: shared widths and entry type for the instruction buffer
package instr_buffer_pkg;
    localparam int INST_W = 32;
    localparam int PC_W   = 48;
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } ibuf_entry_t;
endpackage

// File: rtl/instr_buffer_compact.sv
// ibuf_compact: packs the valid fetch slots of a packet into consecutive entries
import instr_buffer_pkg::*;
module ibuf_compact (
    input  logic [1:0]          mask_i,
    input  logic [2*INST_W-1:0] inst_i,
    input  logic [PC_W-1:0]     pc_i,
    output logic [1:0]          n_o,
    output ibuf_entry_t         e0_o,
    output ibuf_entry_t         e1_o
);
    ibuf_entry_t s0, s1;
    // slot1 always sits at pc+4; a lone slot1 moves down into the first entry
    always_comb begin
        s0   = '{inst: inst_i[INST_W-1:0], pc: pc_i};
        s1   = '{inst: inst_i[2*INST_W-1:INST_W], pc: pc_i + PC_W'(4)};
        n_o  = {1'b0, mask_i[0]} + {1'b0, mask_i[1]};
        e0_o = mask_i[0] ? s0 : s1;
        e1_o = s1;
    end
endmodule

// File: rtl/instr_buffer.sv
// instr_buffer: circular FIFO between fetch (two slots in) and decode (one out)
import instr_buffer_pkg::*;
module instr_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    input  logic [2*INST_W-1:0]      fetch_inst,
    input  logic [PC_W-1:0]          fetch_pc,
    input  logic [1:0]               fetch_mask,
    input  logic                     flush,
    input  logic                     decode_ready,
    output logic                     ibuffer_instr_valid,
    output logic [INST_W-1:0]        ibuffer_inst_out,
    output logic [PC_W-1:0]          ibuffer_pc_out,
    output logic [$clog2(DEPTH):0]   ibuffer_count,
    output logic                     fifo_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    ibuf_entry_t     mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d, tail_p1;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      n_slots, n_enq;
    logic            enq, deq;
    ibuf_entry_t     e0, e1;
    ibuf_compact u_compact (
        .mask_i (fetch_mask),
        .inst_i (fetch_inst),
        .pc_i   (fetch_pc),
        .n_o    (n_slots),
        .e0_o   (e0),
        .e1_o   (e1)
    );
    assign fetch_ready         = count_q <= CW'(DEPTH - 2);
    assign enq                 = fetch_valid & fetch_ready & ~flush;
    assign n_enq               = enq ? n_slots : 2'd0;
    assign ibuffer_instr_valid = (count_q != '0) & ~flush;
    assign deq                 = ibuffer_instr_valid & decode_ready;
    assign tail_p1             = tail_q + PW'(1);
    assign ibuffer_inst_out    = mem_q[head_q].inst;
    assign ibuffer_pc_out      = mem_q[head_q].pc;
    assign ibuffer_count       = count_q;
    assign fifo_empty          = count_q == '0;
    // pointer and occupancy next state; flush overrides everything
    always_comb begin
        head_d  = flush ? '0 : head_q + PW'(deq);
        tail_d  = flush ? '0 : tail_q + PW'(n_enq);
        count_d = flush ? '0 : count_q + CW'(n_enq) - CW'(deq);
    end
    // pointer and occupancy registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
    // entry array; cleared on reset so the head outputs are never X
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (n_enq != 2'd0) mem_q[tail_q] <= e0;
            if (n_enq == 2'd2) mem_q[tail_p1] <= e1;
        end
    end
endmodule

// File: tb/tb_instr_buffer.sv
// tb_instr_buffer: directed self-checking bench for instr_buffer (DEPTH 8)
module tb_instr_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [63:0] fetch_inst = '0;
    logic [47:0] fetch_pc = '0;
    logic [1:0]  fetch_mask = '0;
    logic        flush = 1'b0;
    logic        decode_ready = 1'b0;
    logic        valid;
    logic [31:0] inst_out;
    logic [47:0] pc_out;
    logic [3:0]  count;
    logic        empty;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    instr_buffer #(.DEPTH(8)) dut (
        .clock               (clk),
        .reset               (reset),
        .fetch_valid         (fetch_valid),
        .fetch_ready         (fetch_ready),
        .fetch_inst          (fetch_inst),
        .fetch_pc            (fetch_pc),
        .fetch_mask          (fetch_mask),
        .flush               (flush),
        .decode_ready        (decode_ready),
        .ibuffer_instr_valid (valid),
        .ibuffer_inst_out    (inst_out),
        .ibuffer_pc_out      (pc_out),
        .ibuffer_count       (count),
        .fifo_empty          (empty)
    );

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] m, input logic [31:0] i1, input logic [31:0] i0, input logic [47:0] pc);
        fetch_valid = 1'b1;
        fetch_mask  = m;
        fetch_inst  = {i1, i0};
        fetch_pc    = pc;
        tick();
        fetch_valid = 1'b0;
    endtask

    task automatic head(input string tag, input logic [31:0] i, input logic [47:0] pc);
        check({tag, "_v"}, 80'(valid), 80'(1));
        check({tag, "_inst"}, 80'(inst_out), 80'(i));
        check({tag, "_pc"}, 80'(pc_out), 80'(pc));
    endtask

    initial begin
        #2;
        check("rst_valid", 80'(valid), 80'(0));
        check("rst_empty", 80'(empty), 80'(1));
        check("rst_ready", 80'(fetch_ready), 80'(1));
        check("rst_count", 80'(count), 80'(0));
        check("rst_inst", 80'(inst_out), 80'(0));
        check("rst_pc", 80'(pc_out), 80'(0));
        @(negedge clk);
        reset = 1'b0;
        tick();
        // two-slot push consumed over two cycles
        decode_ready = 1'b1;
        push(2'b11, 32'h00200093, 32'h00100093, 48'h1000);
        check("p11_count", 80'(count), 80'(2));
        head("p11_h0", 32'h00100093, 48'h1000);
        tick();
        head("p11_h1", 32'h00200093, 48'h1004);
        tick();
        check("p11_empty", 80'(empty), 80'(1));
        check("p11_valid", 80'(valid), 80'(0));
        // lone slot1 takes pc+4
        decode_ready = 1'b0;
        push(2'b10, 32'hBBBB0002, 32'hAAAA0001, 48'h2000);
        check("p10_count", 80'(count), 80'(1));
        head("p10", 32'hBBBB0002, 48'h2004);
        decode_ready = 1'b1;
        tick();
        decode_ready = 1'b0;
        check("p10_drained", 80'(count), 80'(0));
        // fill from tail=3 so the third push straddles the wrap at entry 7
        for (int k = 0; k < 3; k++)
            push(2'b11, 32'hC0000000 + 32'(2*k+1), 32'hC0000000 + 32'(2*k), 48'h3000 + 48'(8*k));
        check("fill6_count", 80'(count), 80'(6));
        check("fill6_ready", 80'(fetch_ready), 80'(1));
        push(2'b11, 32'hC0000007, 32'hC0000006, 48'h3018);
        check("fill8_count", 80'(count), 80'(8));
        check("fill8_ready", 80'(fetch_ready), 80'(0));
        push(2'b11, 32'hDEAD0001, 32'hDEAD0000, 48'h9000);
        check("full_ignored", 80'(count), 80'(8));
        decode_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("drain%0d_inst", k), 80'(inst_out), 80'(32'hC0000000 + 32'(k)));
            check($sformatf("drain%0d_pc", k), 80'(pc_out), 80'(48'h3000 + 48'(4*k)));
            tick();
        end
        check("drain_empty", 80'(empty), 80'(1));
        // occupancy 5, then push and pop in the same cycle
        decode_ready = 1'b0;
        push(2'b11, 32'hD0000001, 32'hD0000000, 48'h4000);
        push(2'b11, 32'hD0000003, 32'hD0000002, 48'h4008);
        push(2'b01, 32'hFFFFFFFF, 32'hD0000004, 48'h4010);
        check("occ5_count", 80'(count), 80'(5));
        check("occ5_ready", 80'(fetch_ready), 80'(1));
        push(2'b00, 32'hEEEE0001, 32'hEEEE0000, 48'h7000);
        check("mask00_count", 80'(count), 80'(5));
        decode_ready = 1'b1;
        push(2'b11, 32'hD0000006, 32'hD0000005, 48'h4014);
        check("both_count", 80'(count), 80'(6));
        for (int k = 1; k < 7; k++) begin
            check($sformatf("order%0d", k), 80'(inst_out), 80'(32'hD0000000 + 32'(k)));
            tick();
        end
        check("order_empty", 80'(count), 80'(0));
        // flush at occupancy 4 with a concurrent push
        decode_ready = 1'b0;
        push(2'b11, 32'hE0000001, 32'hE0000000, 48'h5000);
        push(2'b11, 32'hE0000003, 32'hE0000002, 48'h5008);
        check("occ4_count", 80'(count), 80'(4));
        flush        = 1'b1;
        decode_ready = 1'b1;
        fetch_valid  = 1'b1;
        fetch_mask   = 2'b11;
        fetch_inst   = {32'hF0000001, 32'hF0000000};
        fetch_pc     = 48'h6000;
        #1;
        check("flush_valid_low", 80'(valid), 80'(0));
        tick();
        flush       = 1'b0;
        fetch_valid = 1'b0;
        decode_ready = 1'b0;
        check("flush_count", 80'(count), 80'(0));
        check("flush_empty", 80'(empty), 80'(1));
        check("flush_valid", 80'(valid), 80'(0));
        push(2'b01, 32'h0, 32'h12340000, 48'h8000);
        check("post_flush_count", 80'(count), 80'(1));
        head("post_flush", 32'h12340000, 48'h8000);
        // asynchronous reset mid-operation
        #2;
        reset = 1'b1;
        #1;
        check("arst_count", 80'(count), 80'(0));
        check("arst_valid", 80'(valid), 80'(0));
        check("arst_inst", 80'(inst_out), 80'(0));
        check("arst_ready", 80'(fetch_ready), 80'(1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
